// File: rtl/load_rs_param.sv
// Load reservation station: holds loads until base reg and older store resolve, issues oldest ready by ROB age.
// Issue is registered-state only (1-cycle wake-to-issue); iss_* hold under backpressure; disp_ready from registered occupancy.
module load_rs_param #(
    parameter int DEPTH      = 8,
    parameter int NUM_CDB_IN = 3,
    parameter int NUM_ST_RES = 1,
    parameter int PREG_BITS  = 6,
    parameter int ROB_BITS   = 6,
    parameter int PAYLOAD_W  = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             disp_valid,
    output logic                             disp_ready,
    input  logic [PREG_BITS-1:0]             disp_ps1_s,
    input  logic                             disp_ps1_rdy,
    input  logic [PREG_BITS-1:0]             disp_pd_s,
    input  logic [ROB_BITS-1:0]              disp_rob,
    input  logic                             disp_dep_valid,
    input  logic [ROB_BITS-1:0]              disp_dep_rob,
    input  logic [PAYLOAD_W-1:0]             disp_payload,
    input  logic [NUM_CDB_IN-1:0]            cdb_valid,
    input  logic [NUM_CDB_IN*PREG_BITS-1:0]  cdb_pd_s,
    input  logic [NUM_ST_RES-1:0]            st_res_valid,
    input  logic [NUM_ST_RES*ROB_BITS-1:0]   st_res_rob,
    input  logic [ROB_BITS-1:0]              rob_head,
    input  logic                             flush_valid,
    input  logic [ROB_BITS-1:0]              flush_rob,
    output logic                             iss_valid,
    input  logic                             iss_ready,
    output logic [PREG_BITS-1:0]             iss_ps1_s,
    output logic [PREG_BITS-1:0]             iss_pd_s,
    output logic [ROB_BITS-1:0]              iss_rob,
    output logic [PAYLOAD_W-1:0]             iss_payload,
    output logic [$clog2(DEPTH):0]           occupancy
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {EMPTY, WAIT_FOR_STORE, WAIT_FOR_REG, READY} ent_st_e;

    ent_st_e                state_q [DEPTH];
    ent_st_e                state_d [DEPTH];
    logic                   reg_rdy_q [DEPTH];
    logic                   reg_rdy_d [DEPTH];
    logic [PREG_BITS-1:0]   ps1_q [DEPTH];
    logic [PREG_BITS-1:0]   ps1_d [DEPTH];
    logic [PREG_BITS-1:0]   pd_q [DEPTH];
    logic [PREG_BITS-1:0]   pd_d [DEPTH];
    logic [ROB_BITS-1:0]    rob_q [DEPTH];
    logic [ROB_BITS-1:0]    rob_d [DEPTH];
    logic [ROB_BITS-1:0]    dep_q [DEPTH];
    logic [ROB_BITS-1:0]    dep_d [DEPTH];
    logic [PAYLOAD_W-1:0]   pay_q [DEPTH];
    logic [PAYLOAD_W-1:0]   pay_d [DEPTH];
    logic [CW-1:0]          occ_q;
    logic [CW-1:0]          occ_d;

    logic                   free_found;
    logic [IW-1:0]          free_idx;
    logic                   sel_found;
    logic [IW-1:0]          sel_idx;
    logic [ROB_BITS-1:0]    sel_age;
    logic                   disp_fire;
    logic                   iss_fire;
    logic [ROB_BITS-1:0]    flush_age;
    logic                   dup_rob;

    // Tag 0 is the hard-wired zero register and never waits.
    function automatic logic cdb_hit(input logic [PREG_BITS-1:0] tag);
        logic hit;
        hit = (tag == '0);
        for (int i = 0; i < NUM_CDB_IN; i++)
            if (cdb_valid[i] && cdb_pd_s[i*PREG_BITS +: PREG_BITS] == tag) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic st_hit(input logic [ROB_BITS-1:0] rob);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < NUM_ST_RES; j++)
            if (st_res_valid[j] && st_res_rob[j*ROB_BITS +: ROB_BITS] == rob) hit = 1'b1;
        return hit;
    endfunction

    always_comb begin
        logic [ROB_BITS-1:0] cand_age;
        cand_age   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_age    = '0;
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (state_q[e] == EMPTY) begin
                free_found = 1'b1;
                free_idx   = IW'(e);
            end
        end
        // Strict compare in ascending order keeps the lower index on equal age.
        for (int e = 0; e < DEPTH; e++) begin
            cand_age = rob_q[e] - rob_head;
            if (state_q[e] == READY && (!sel_found || cand_age < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(e);
                sel_age   = cand_age;
            end
        end
    end

    assign disp_ready  = free_found;
    assign iss_valid   = sel_found;
    assign iss_ps1_s   = ps1_q[sel_idx];
    assign iss_pd_s    = pd_q[sel_idx];
    assign iss_rob     = rob_q[sel_idx];
    assign iss_payload = pay_q[sel_idx];
    assign occupancy   = occ_q;
    assign disp_fire   = disp_valid && free_found && !flush_valid;
    assign iss_fire    = sel_found && iss_ready;
    assign flush_age   = flush_rob - rob_head;

    always_comb begin
        logic                wake;
        logic                rr;
        logic                dep_clear;
        logic [ROB_BITS-1:0] ent_age;
        wake      = 1'b0;
        rr        = 1'b0;
        dep_clear = 1'b0;
        ent_age   = '0;
        occ_d     = '0;
        for (int e = 0; e < DEPTH; e++) begin
            state_d[e]   = state_q[e];
            reg_rdy_d[e] = reg_rdy_q[e];
            ps1_d[e]     = ps1_q[e];
            pd_d[e]      = pd_q[e];
            rob_d[e]     = rob_q[e];
            dep_d[e]     = dep_q[e];
            pay_d[e]     = pay_q[e];
            wake         = cdb_hit(ps1_q[e]);
            ent_age      = rob_q[e] - rob_head;
            case (state_q[e])
                WAIT_FOR_STORE: begin
                    reg_rdy_d[e] = reg_rdy_q[e] | wake;
                    if (st_hit(dep_q[e]))
                        state_d[e] = (reg_rdy_q[e] | wake) ? READY : WAIT_FOR_REG;
                end
                WAIT_FOR_REG: begin
                    if (wake) begin
                        state_d[e]   = READY;
                        reg_rdy_d[e] = 1'b1;
                    end
                end
                default: ;
            endcase
            if (state_q[e] != EMPTY && flush_valid && ent_age > flush_age)
                state_d[e] = EMPTY;
            if (iss_fire && sel_idx == IW'(e))
                state_d[e] = EMPTY;
            if (disp_fire && free_idx == IW'(e)) begin
                rr        = disp_ps1_rdy | cdb_hit(disp_ps1_s);
                dep_clear = !disp_dep_valid | st_hit(disp_dep_rob);
                reg_rdy_d[e] = rr;
                ps1_d[e]     = disp_ps1_s;
                pd_d[e]      = disp_pd_s;
                rob_d[e]     = disp_rob;
                dep_d[e]     = disp_dep_rob;
                pay_d[e]     = disp_payload;
                state_d[e]   = !dep_clear ? WAIT_FOR_STORE : (!rr ? WAIT_FOR_REG : READY);
            end
            if (state_d[e] != EMPTY) occ_d = occ_d + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                state_q[e]   <= EMPTY;
                reg_rdy_q[e] <= 1'b0;
                ps1_q[e]     <= '0;
                pd_q[e]      <= '0;
                rob_q[e]     <= '0;
                dep_q[e]     <= '0;
                pay_q[e]     <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                state_q[e]   <= state_d[e];
                reg_rdy_q[e] <= reg_rdy_d[e];
                ps1_q[e]     <= ps1_d[e];
                pd_q[e]      <= pd_d[e];
                rob_q[e]     <= rob_d[e];
                dep_q[e]     <= dep_d[e];
                pay_q[e]     <= pay_d[e];
            end
            occ_q <= occ_d;
        end
    end

    always_comb begin
        dup_rob = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            for (int j = i + 1; j < DEPTH; j++)
                if (state_q[i] != EMPTY && state_q[j] != EMPTY && rob_q[i] == rob_q[j])
                    dup_rob = 1'b1;
    end

    a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n) occ_q <= CW'(DEPTH));
    a_rob_unique: assert property (@(posedge clk) disable iff (!rst_n) !dup_rob);
endmodule

// File: tb/tb_load_rs_param.sv
// Bench for load_rs_param: directed scenarios plus random traffic against a queue-based load model.
module tb_load_rs_param;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        disp_valid = 1'b0, disp_ready;
    logic [5:0]  disp_ps1_s = '0, disp_pd_s = '0, disp_rob = '0, disp_dep_rob = '0;
    logic        disp_ps1_rdy = 1'b0, disp_dep_valid = 1'b0;
    logic [31:0] disp_payload = '0;
    logic [2:0]  cdb_valid = '0;
    logic [17:0] cdb_pd_s = '0;
    logic [0:0]  st_res_valid = '0;
    logic [5:0]  st_res_rob = '0, rob_head = '0, flush_rob = '0;
    logic        flush_valid = 1'b0, iss_valid, iss_ready = 1'b0;
    logic [5:0]  iss_ps1_s, iss_pd_s, iss_rob;
    logic [31:0] iss_payload;
    logic [3:0]  occupancy;

    load_rs_param dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_ps1_s(disp_ps1_s), .disp_ps1_rdy(disp_ps1_rdy), .disp_pd_s(disp_pd_s),
        .disp_rob(disp_rob), .disp_dep_valid(disp_dep_valid), .disp_dep_rob(disp_dep_rob),
        .disp_payload(disp_payload), .cdb_valid(cdb_valid), .cdb_pd_s(cdb_pd_s),
        .st_res_valid(st_res_valid), .st_res_rob(st_res_rob), .rob_head(rob_head),
        .flush_valid(flush_valid), .flush_rob(flush_rob),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_ps1_s(iss_ps1_s),
        .iss_pd_s(iss_pd_s), .iss_rob(iss_rob), .iss_payload(iss_payload),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst_n, dv, ps1_rdy, depv, st_v, flush, iss_ready;
        logic [5:0] ps1, pd, rob, dep_rob, st_rob, flush_rob, head;
        logic [2:0] cdbv;
        logic [17:0] cdb_tags;
        logic [31:0] pay;
    } stim_t;

    typedef struct { logic [5:0] rob, ps1, pd, dep_rob; logic [31:0] pay; bit rr, dep; } ld_t;
    typedef struct { int cyc; bit v; int occ; bit dr; } stat_t;
    typedef struct { int cyc; logic [5:0] rob, ps1, pd; logic [31:0] pay; } iss_t;

    ld_t   mq[$];
    stat_t stq[$];
    iss_t  isq[$];
    bit    mvalid = 0;
    bit    last_accept;
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    logic [5:0] head_g = '0;

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endfunction

    function automatic logic [5:0] age(logic [5:0] r, logic [5:0] h);
        return r - h;
    endfunction

    function automatic bit m_cdb(stim_t s, logic [5:0] tag);
        logic [5:0] t;
        if (tag == 6'd0) return 1;
        for (int i = 0; i < 3; i++) begin
            t = s.cdb_tags[i*6 +: 6];
            if (s.cdbv[i] && t == tag) return 1;
        end
        return 0;
    endfunction

    function automatic bit m_st(stim_t s, logic [5:0] r);
        return s.st_v && s.st_rob == r;
    endfunction

    function automatic stim_t idle(bit rdy);
        stim_t s;
        s = '{rst_n: 1'b1, dv: 1'b0, ps1_rdy: 1'b0, depv: 1'b0, st_v: 1'b0, flush: 1'b0,
              iss_ready: rdy, ps1: '0, pd: '0, rob: '0, dep_rob: '0, st_rob: '0,
              flush_rob: '0, head: head_g, cdbv: '0, cdb_tags: '0, pay: '0};
        return s;
    endfunction

    task automatic step(input stim_t s);
        int   sel;
        ld_t  nq[$];
        ld_t  e;
        @(posedge clk);
        #1;
        rst_n = s.rst_n; disp_valid = s.dv; disp_ps1_s = s.ps1; disp_ps1_rdy = s.ps1_rdy;
        disp_pd_s = s.pd; disp_rob = s.rob; disp_dep_valid = s.depv; disp_dep_rob = s.dep_rob;
        disp_payload = s.pay; cdb_valid = s.cdbv; cdb_pd_s = s.cdb_tags;
        st_res_valid = s.st_v; st_res_rob = s.st_rob; rob_head = s.head;
        flush_valid = s.flush; flush_rob = s.flush_rob; iss_ready = s.iss_ready;
        sel = -1;
        foreach (mq[i])
            if (mq[i].rr && !mq[i].dep)
                if (sel < 0 || age(mq[i].rob, s.head) < age(mq[sel].rob, s.head)) sel = i;
        if (mvalid) begin
            stq.push_back('{cyc: cyc, v: sel >= 0, occ: mq.size(), dr: mq.size() < DEPTH});
            if (sel >= 0)
                isq.push_back('{cyc: cyc, rob: mq[sel].rob, ps1: mq[sel].ps1, pd: mq[sel].pd, pay: mq[sel].pay});
        end
        last_accept = 0;
        if (!s.rst_n) begin
            mq.delete();
            mvalid = 1;
        end else begin
            last_accept = s.dv && mq.size() < DEPTH && !s.flush;
            foreach (mq[i]) begin
                if (i == sel && s.iss_ready) continue;
                if (s.flush && age(mq[i].rob, s.head) > age(s.flush_rob, s.head)) continue;
                e = mq[i];
                if (e.dep && m_st(s, e.dep_rob)) e.dep = 0;
                if (m_cdb(s, e.ps1)) e.rr = 1;
                nq.push_back(e);
            end
            if (last_accept) begin
                e = '{rob: s.rob, ps1: s.ps1, pd: s.pd, dep_rob: s.dep_rob, pay: s.pay,
                      rr: s.ps1_rdy || m_cdb(s, s.ps1), dep: s.depv && !m_st(s, s.dep_rob)};
                nq.push_back(e);
            end
            mq = nq;
        end
        cyc++;
    endtask

    task automatic disp(input logic [5:0] rob, input logic [5:0] ps1, input bit rdy,
                        input bit depv, input logic [5:0] dep_rob, input bit iss_rdy);
        stim_t s;
        s = idle(iss_rdy);
        s.dv = 1; s.rob = rob; s.ps1 = ps1; s.ps1_rdy = rdy; s.depv = depv; s.dep_rob = dep_rob;
        s.pd = rob + 6'd1; s.pay = $urandom;
        step(s);
    endtask

    task automatic idles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(idle(rdy));
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle(1'b0);
        s.rst_n = 0;
        step(s);
        step(s);
    endtask

    // Monitor: one status record per cycle, plus an issue record whenever the DUT presents a load.
    initial begin
        stat_t st;
        iss_t  r;
        forever begin
            @(negedge clk);
            if (stq.size() == 0) continue;
            st = stq.pop_front();
            chk("iss_valid", 64'(iss_valid), 64'(st.v));
            chk("occupancy", 64'(occupancy), 64'(st.occ));
            chk("disp_ready", 64'(disp_ready), 64'(st.dr));
            if (iss_valid) begin
                if (isq.size() > 0 && isq[0].cyc == st.cyc) begin
                    r = isq.pop_front();
                    chk("iss_rob", 64'(iss_rob), 64'(r.rob));
                    chk("iss_ps1_s", 64'(iss_ps1_s), 64'(r.ps1));
                    chk("iss_pd_s", 64'(iss_pd_s), 64'(r.pd));
                    chk("iss_payload", 64'(iss_payload), 64'(r.pay));
                end
            end
            while (isq.size() > 0 && isq[0].cyc <= st.cyc) void'(isq.pop_front());
        end
    end

    initial begin
        stim_t s;
        logic [5:0] next_rob;
        bit clash;

        // Single ready load issues the cycle after dispatch.
        do_reset();
        disp(6'd5, 6'd3, 1, 0, 6'd0, 0);
        idles(3, 1);

        // Register wakeup from CDB port 2, and wakeup in the dispatch cycle itself.
        disp(6'd6, 6'd12, 0, 0, 6'd0, 1);
        idles(2, 1);
        s = idle(1); s.cdbv = 3'b100; s.cdb_tags[12 +: 6] = 6'd12; step(s);
        idles(2, 1);
        s = idle(1); s.dv = 1; s.rob = 6'd7; s.ps1 = 6'd12; s.pay = 32'hCAFE_0007;
        s.cdbv = 3'b001; s.cdb_tags[5:0] = 6'd12; step(s);
        idles(2, 1);

        // Store dependency, then store resolve together with CDB while reg not ready.
        disp(6'd8, 6'd9, 1, 1, 6'd3, 1);
        idles(2, 1);
        s = idle(1); s.st_v = 1; s.st_rob = 6'd3; step(s);
        idles(2, 1);
        disp(6'd9, 6'd20, 0, 1, 6'd3, 1);
        idles(1, 1);
        s = idle(1); s.st_v = 1; s.st_rob = 6'd3; s.cdbv = 3'b010; s.cdb_tags[6 +: 6] = 6'd20; step(s);
        idles(2, 1);

        // Age wraps around the ROB head.
        head_g = 6'd60;
        disp(6'd62, 6'd0, 1, 0, 6'd0, 0);
        disp(6'd1, 6'd0, 1, 0, 6'd0, 0);
        idles(1, 0);
        idles(3, 1);

        // Fill, overflow attempt, partial flush.
        do_reset();
        head_g = 6'd10;
        for (int i = 0; i < 8; i++) disp(6'(10 + i), 6'd0, 1, 0, 6'd0, 0);
        disp(6'd40, 6'd0, 1, 0, 6'd0, 0);
        s = idle(0); s.flush = 1; s.flush_rob = 6'd13; step(s);
        idles(6, 1);

        // Reset with waiting entries discards them; a later CDB wakes nothing.
        head_g = 6'd0;
        for (int i = 0; i < 5; i++) disp(6'(20 + i), (i % 2 == 0) ? 6'd40 : 6'd0, 0, 0, 6'd0, 0);
        do_reset();
        s = idle(1); s.cdbv = 3'b001; s.cdb_tags[5:0] = 6'd40; step(s);
        idles(2, 1);

        // Random traffic.
        next_rob = 6'd30;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 19) == 0) head_g = 6'($urandom);
            s = idle($urandom_range(0, 9) < 7);
            s.rst_n = ($urandom_range(0, 399) != 0);
            s.dv = ($urandom_range(0, 9) < 6);
            do begin
                clash = 0;
                foreach (mq[i]) if (mq[i].rob == next_rob) clash = 1;
                if (clash) next_rob = next_rob + 6'd1;
            end while (clash);
            s.rob = next_rob;
            s.ps1 = 6'($urandom_range(0, 15));
            s.ps1_rdy = ($urandom_range(0, 9) < 3);
            s.pd = 6'($urandom);
            s.pay = $urandom;
            s.depv = ($urandom_range(0, 9) < 3);
            s.dep_rob = 6'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) begin
                s.cdbv[i] = ($urandom_range(0, 9) < 4);
                s.cdb_tags[i*6 +: 6] = 6'($urandom_range(0, 15));
            end
            s.st_v = ($urandom_range(0, 3) == 0);
            s.st_rob = 6'($urandom_range(0, 7));
            s.flush = ($urandom_range(0, 24) == 0);
            s.flush_rob = 6'($urandom);
            step(s);
            if (last_accept) next_rob = next_rob + 6'd1;
        end
        idles(12, 1);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(stq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_rs_param.md
Name: load_rs_param

Overview:
Parametrised load reservation station for the out-of-order RV32 core. It sits between rename/dispatch and the load/store unit. Each entry holds a load until two conditions are met: its base register (ps1) has been produced on any CDB, and the older store it depends on has resolved. It then issues the oldest ready load, measured relative to the ROB head. Compared with the fixed single-CDB version, it adds configurable depth, N CDB snoop ports, M store-resolve ports, same-cycle wakeup bypass, and partial (ROB-age) flush.

Parameters:
DEPTH, 8, number of entries (power of two, >=2)
NUM_CDB_IN, 3, CDB snoop ports
NUM_ST_RES, 1, store-resolve ports per cycle
PREG_BITS, 6, physical register tag width
ROB_BITS, 6, ROB index width; ages compare modulo 2^ROB_BITS
PAYLOAD_W, 32, opaque payload width (instr/rvfi bits), carried unchanged

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
disp_valid  in  1  dispatch request
disp_ready  out  1  at least one EMPTY entry
disp_ps1_s  in  PREG_BITS  base register tag
disp_ps1_rdy  in  1  ps1 already valid in the regfile
disp_pd_s  in  PREG_BITS  destination tag
disp_rob  in  ROB_BITS  ROB index of the load
disp_dep_valid  in  1  load depends on an older store
disp_dep_rob  in  ROB_BITS  ROB index of that store
disp_payload  in  PAYLOAD_W  opaque payload
cdb_valid  in  NUM_CDB_IN  per-port valid
cdb_pd_s  in  NUM_CDB_IN*PREG_BITS  per-port tag
st_res_valid  in  NUM_ST_RES  store resolved (address known)
st_res_rob  in  NUM_ST_RES*ROB_BITS  ROB index of the resolved store
rob_head  in  ROB_BITS  current ROB head, used as the age base
flush_valid  in  1  squash request
flush_rob  in  ROB_BITS  squash entries strictly younger than this ROB index
iss_valid  out  1  a READY entry is presented
iss_ready  in  1  load unit accepts
iss_ps1_s  out  PREG_BITS  tag of the issued entry
iss_pd_s  out  PREG_BITS  tag of the issued entry
iss_rob  out  ROB_BITS  ROB index of the issued entry
iss_payload  out  PAYLOAD_W  payload of the issued entry
occupancy  out  $clog2(DEPTH)+1  count of non-EMPTY entries

Behaviour:
- Entry state: EMPTY / WAIT_FOR_STORE / WAIT_FOR_REG / READY, plus a per-entry reg_rdy bit.
- Reset (rst_n=0 at a clock edge): all entries EMPTY and fields zeroed; outputs become iss_valid=0, disp_ready=1, occupancy=0. Reset mid-operation discards all contents.
- Wake match: ps1 matches when any cdb_valid[i] has cdb_pd_s[i]==ps1_s. Tag 0 is always ready.
- Dispatch fires when disp_valid && disp_ready && !flush_valid.
  - Allocates the lowest-index EMPTY entry.
  - reg_rdy = disp_ps1_rdy OR (a same-cycle CDB matches disp_ps1_s) OR ps1_s==0.
  - Store dependency is cleared if disp_dep_valid=0 or a same-cycle st_res matches disp_dep_rob.
  - Next state: dependency still pending -> WAIT_FOR_STORE; else reg_rdy=0 -> WAIT_FOR_REG; else READY.
- WAIT_FOR_STORE: a CDB match sets reg_rdy. A st_res_rob match moves the entry to READY if reg_rdy (including a same-cycle CDB match), else WAIT_FOR_REG.
- WAIT_FOR_REG: a CDB match moves the entry to READY.
- Issue selection:
  - iss_* outputs are combinational from registered state only; no CDB→issue path in the same cycle.
  - Latency: a dispatch or wake at cycle t gives earliest iss_valid at t+1.
  - Among READY entries, pick minimum age = (rob - rob_head) mod 2^ROB_BITS; ties go to the lower index.
  - When iss_valid && iss_ready, the selected entry becomes EMPTY next cycle. The entry may be reallocated by dispatch one cycle later; no same-cycle reuse (disp_ready reflects registered state).
  - iss_* fields hold stable while iss_valid=1 && iss_ready=0, unless an older entry becomes READY.
- Flush:
  - Kills every non-EMPTY entry with age(rob) > age(flush_rob); effective next cycle.
  - Dispatch is suppressed in a flush cycle.
  - Issue handshake in a flush cycle still completes, and the entry empties regardless.
  - Surviving entries keep their state and still observe CDB/st_res in the flush cycle.
- Full: disp_ready=0 when all DEPTH entries are non-EMPTY; disp_valid is ignored.
- Empty: iss_valid=0.
- occupancy is registered and updates the cycle after the event: +1 per dispatch, -1 per issue, minus the kill count; simultaneous dispatch and issue leave it unchanged.
- Assertions: occupancy <= DEPTH; no two non-EMPTY entries share a rob.

Test Plan:
1. Reset, then dispatch rob=5, ps1_rdy=1, no dependency → iss_valid=1 next cycle with iss_rob=5; accept → occupancy returns to 0.
2. Dispatch ps1_s=12, ps1_rdy=0 → WAIT_FOR_REG; cdb port 2 shows pd_s=12 at cycle t → iss_valid=1 at t+1. Also: CDB pd_s=12 in the dispatch cycle itself → iss_valid the next cycle.
3. Dispatch with dep_rob=3, ps1 ready → no issue; st_res_rob=3 at t → issue at t+1. Repeat with the CDB and st_res in the same cycle while reg is not ready → READY at t+1.
4. rob_head=60; READY entries rob=62 and rob=1 (wrapped) → rob=62 issues first, then rob=1.
5. Fill 8 entries (rob 10..17) → disp_ready=0; flush_rob=13 → next cycle occupancy=4, disp_ready=1; only rob 10..13 ever issue.
6. Assert rst_n=0 with 5 entries occupied, some waiting → next cycle occupancy=0, iss_valid=0; an earlier pending CDB tag no longer wakes anything.
